// File: rtl/sr_cmd_debouncer_if.sv
// Command bus between the button front end and the SR latch driver:
// raw button levels flow in, the clean S/R pulses and status flow out.
interface sr_cmd_debouncer_if;
    logic set_btn;
    logic rst_btn;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    modport master (
        output set_btn,
        output rst_btn,
        input  S,
        input  R,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_btn,
        input  rst_btn,
        output S,
        output R,
        output busy,
        output conflict
    );
endinterface

// File: rtl/sr_cmd_debouncer.sv
// Synchronises and debounces the set/reset buttons, then turns each accepted
// press into a fixed-length S or R pulse; simultaneous presses are rejected.
module sr_cmd_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_cmd_debouncer_if.slave  bus,
    output logic [1:0]         state_dbg_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, SET_P = 2'd1, RST_P = 2'd2, CONFL = 2'd3} state_e;

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PW = $clog2(PULSE_LEN) + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PULSE_LEN - 1);
    localparam logic [PW-1:0] PCNT_ONE = PW'(1);

    // Channel index 0 is the set button, index 1 is the reset button.
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          stable_q, stable_d;
    logic [1:0]          pend_q, pend_d;
    logic [1:0]          rise;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    state_e              state_q, state_d;
    logic                s_q, r_q, busy_q, conf_q;
    logic                s_d, r_d, busy_d, conf_d;

    // State register: everything, outputs included, updates on the rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            state_q  <= IDLE;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            busy_q   <= 1'b0;
            conf_q   <= 1'b0;
        end else begin
            sync1_q  <= {bus.rst_btn, bus.set_btn};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            state_q  <= state_d;
            s_q      <= s_d;
            r_q      <= r_d;
            busy_q   <= busy_d;
            conf_q   <= conf_d;
        end
    end

    // Debounce: the stable level follows sync2 only after it has differed
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        rise = stable_d & ~stable_q;
    end

    // Next-state logic; a fresh press on the same edge as a consume wins.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (pend_q == 2'b11) begin
                    state_d = CONFL;
                    pend_d  = 2'b00;
                end else if (pend_q[0]) begin
                    state_d   = SET_P;
                    pend_d[0] = 1'b0;
                    pcnt_d    = '0;
                end else if (pend_q[1]) begin
                    state_d   = RST_P;
                    pend_d[1] = 1'b0;
                    pcnt_d    = '0;
                end
            end
            SET_P, RST_P: begin
                if (pcnt_q == PCNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    pcnt_d = pcnt_q + PCNT_ONE;
                end
            end
            CONFL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pend_d = pend_d | rise;
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        s_d    = (state_d == SET_P);
        r_d    = (state_d == RST_P);
        conf_d = (state_d == CONFL);
        busy_d = (state_d != IDLE);
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conf_q;
    assign state_dbg_o  = state_q;
endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer: one instance with default pulse length,
// one with PULSE_LEN=3, both sharing clock and reset.
module tb_sr_cmd_debouncer;
    logic clk;
    logic rst_n;
    logic [1:0] st_a, st_b;
    logic q_a;
    logic checking;
    int total;
    int fails;

    sr_cmd_debouncer_if bus_a ();
    sr_cmd_debouncer_if bus_b ();

    sr_cmd_debouncer #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(1)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_a.slave),
        .state_dbg_o (st_a)
    );

    sr_cmd_debouncer #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(3)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_b.slave),
        .state_dbg_o (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream SR latch fed by instance A.
    always @(posedge clk) begin
        if (!rst_n)        q_a <= 1'b0;
        else if (bus_a.S)  q_a <= 1'b1;
        else if (bus_a.R)  q_a <= 1'b0;
    end

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("s_and_r_a", {1'b0, bus_a.S & bus_a.R}, 2'd0);
            chk("s_and_r_b", {1'b0, bus_b.S & bus_b.R}, 2'd0);
        end
    end

    initial begin
        total = 0;
        fails = 0;
        checking = 1'b0;
        bus_a.set_btn = 1'($urandom_range(0, 1));
        bus_a.rst_btn = 1'($urandom_range(0, 1));
        bus_b.set_btn = 1'($urandom_range(0, 1));
        bus_b.rst_btn = 1'($urandom_range(0, 1));
        rst_n = 1'b0;

        // 1: reset with random buttons
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("rst_S",        {1'b0, bus_a.S},        2'd0);
            chk("rst_R",        {1'b0, bus_a.R},        2'd0);
            chk("rst_busy",     {1'b0, bus_a.busy},     2'd0);
            chk("rst_conflict", {1'b0, bus_a.conflict}, 2'd0);
            chk("rst_state_a",  st_a,                   2'd0);
            chk("rst_state_b",  st_b,                   2'd0);
            bus_a.set_btn = 1'($urandom_range(0, 1));
            bus_a.rst_btn = 1'($urandom_range(0, 1));
        end
        checking = 1'b1;
        bus_a.set_btn = 1'b0;
        bus_a.rst_btn = 1'b0;
        bus_b.set_btn = 1'b0;
        bus_b.rst_btn = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("idle_state_a", st_a, 2'd0);

        // 2: clean set press, S exactly one cycle, 6 cycles after sampling edge
        bus_a.set_btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("press_S",    {1'b0, bus_a.S},    {1'b0, k == 7});
            chk("press_R",    {1'b0, bus_a.R},    2'd0);
            chk("press_busy", {1'b0, bus_a.busy}, {1'b0, k == 7});
        end
        chk("latch_q", {1'b0, q_a}, 2'd1);
        bus_a.set_btn = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("release_S", {1'b0, bus_a.S}, 2'd0);
        end

        // Glitch of 3 cycles is rejected
        bus_a.set_btn = 1'b1;
        for (int k = 0; k < 3; k++) step();
        bus_a.set_btn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("glitch_S", {1'b0, bus_a.S}, 2'd0);
        end

        // 3: bounce 1,0,1,0 then steady
        for (int k = 0; k < 4; k++) begin
            bus_a.set_btn = (k % 2 == 0);
            step();
            chk("bounce_S", {1'b0, bus_a.S}, 2'd0);
        end
        bus_a.set_btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("bounce_steady_S", {1'b0, bus_a.S}, {1'b0, k == 7});
        end
        bus_a.set_btn = 1'b0;
        for (int k = 0; k < 8; k++) step();

        // 4: simultaneous press -> one conflict, no pulses, even when held
        bus_a.set_btn = 1'b1;
        bus_a.rst_btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("conf_flag", {1'b0, bus_a.conflict}, {1'b0, k == 7});
            chk("conf_busy", {1'b0, bus_a.busy},     {1'b0, k == 7});
            chk("conf_S",    {1'b0, bus_a.S},        2'd0);
            chk("conf_R",    {1'b0, bus_a.R},        2'd0);
            chk("conf_state", st_a, (k == 7) ? 2'd3 : 2'd0);
        end
        bus_a.set_btn = 1'b0;
        bus_a.rst_btn = 1'b0;
        for (int k = 0; k < 8; k++) step();

        // 5: PULSE_LEN=3, reset press then set press one cycle later
        bus_b.rst_btn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) bus_b.set_btn = 1'b1;
            chk("seq_R",    {1'b0, bus_b.R},    {1'b0, k >= 7 && k <= 9});
            chk("seq_S",    {1'b0, bus_b.S},    {1'b0, k >= 11 && k <= 13});
            chk("seq_busy", {1'b0, bus_b.busy}, {1'b0, (k >= 7 && k <= 9) || (k >= 11 && k <= 13)});
        end
        bus_b.rst_btn = 1'b0;
        bus_b.set_btn = 1'b0;
        for (int k = 0; k < 8; k++) step();

        // 6: reset in the middle of a 3-cycle S pulse
        bus_b.set_btn = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        chk("mid_S", {1'b0, bus_b.S}, 2'd1);
        chk("mid_state", st_b, 2'd1);
        rst_n = 1'b0;
        bus_b.set_btn = 1'b0;
        step();
        chk("abort_S",    {1'b0, bus_b.S},    2'd0);
        chk("abort_busy", {1'b0, bus_b.busy}, 2'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("post_rst_S",    {1'b0, bus_b.S},    2'd0);
            chk("post_rst_busy", {1'b0, bus_b.busy}, 2'd0);
        end
        bus_b.set_btn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("repress_S", {1'b0, bus_b.S}, {1'b0, k >= 7 && k <= 9});
        end
        bus_b.set_btn = 1'b0;
        step();

        checking = 1'b0;
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
